// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue controller: holds the pc, fetches 32-bit words over req/ack,
// presents op/argument fields to the datapath and executes jump, branch and halt itself.
//
// state | meaning
// IDLE  | after reset, waiting for run
// FETCH | mem_req high at pc, waiting for mem_ack or timeout
// EXEC  | one cycle: issue strobe for datapath ops, or control-flow action
// WAIT  | remaining exec_cyc-1 cycles of a datapath op
// HALT  | stopped by HALT op or fetch timeout, waiting for run
module fetch_sequencer #(
  parameter int w        = 8,
  parameter int op_w     = 3,
  parameter int addr_w   = 8,
  parameter int exec_cyc = 2,
  parameter int timeout  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic [addr_w-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [31:0]       mem_data,
  output logic [op_w-1:0]   i0,
  output logic [w-1:0]      i1,
  output logic [w-1:0]      i2,
  output logic [w-1:0]      i3,
  output logic              exec_en,
  input  logic              alu_status,
  output logic [addr_w-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WAIT, HALT} state_t;

  localparam logic [op_w-1:0] OP_DP_LO = op_w'(1);
  localparam logic [op_w-1:0] OP_DP_HI = op_w'(4);
  localparam logic [op_w-1:0] OP_BRS   = op_w'(5);
  localparam logic [op_w-1:0] OP_JMP   = op_w'(6);
  localparam logic [op_w-1:0] OP_HALT  = op_w'(7);

  state_t            state, state_n;
  logic [addr_w-1:0] pc_n;
  logic [7:0]        tcnt, tcnt_n;
  logic [3:0]        wcnt, wcnt_n;
  logic              fault_n;
  logic              load_instr;
  logic              is_dp;

  // Op-byte bits above the op field carry no meaning for this controller.
  logic unused_op_bits;
  assign unused_op_bits = ^mem_data[31:24+op_w];

  assign mem_addr = pc;
  assign is_dp    = (i0 >= OP_DP_LO) && (i0 <= OP_DP_HI);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      i0    <= '0;
      i1    <= '0;
      i2    <= '0;
      i3    <= '0;
      tcnt  <= '0;
      wcnt  <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      tcnt  <= tcnt_n;
      wcnt  <= wcnt_n;
      fault <= fault_n;
      if (load_instr) begin
        i0 <= mem_data[24 +: op_w];
        i1 <= mem_data[16 +: w];
        i2 <= mem_data[8 +: w];
        i3 <= mem_data[0 +: w];
      end
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    tcnt_n     = tcnt;
    wcnt_n     = wcnt;
    fault_n    = fault;
    load_instr = 1'b0;
    mem_req    = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    exec_en    = 1'b0;

    case (state)
      IDLE: begin
        if (run) begin
          tcnt_n  = '0;
          state_n = FETCH;
        end
      end

      FETCH: begin
        mem_req = 1'b1;
        busy    = 1'b1;
        if (mem_ack) begin
          load_instr = 1'b1;
          pc_n       = pc + addr_w'(1);
          tcnt_n     = '0;
          state_n    = EXEC;
        end else if (tcnt == 8'(timeout - 1)) begin
          fault_n = 1'b1;
          tcnt_n  = '0;
          state_n = HALT;
        end else begin
          tcnt_n = tcnt + 8'd1;
        end
      end

      EXEC: begin
        busy    = 1'b1;
        state_n = FETCH;
        if (is_dp) begin
          exec_en = 1'b1;
          if (exec_cyc > 1) begin
            wcnt_n  = 4'(exec_cyc - 2);
            state_n = WAIT;
          end
        end else if (i0 == OP_BRS) begin
          if (alu_status) pc_n = i1[addr_w-1:0];
        end else if (i0 == OP_JMP) begin
          pc_n = i1[addr_w-1:0];
        end else if (i0 == OP_HALT) begin
          state_n = HALT;
        end
      end

      WAIT: begin
        busy = 1'b1;
        if (wcnt == 4'd0) state_n = FETCH;
        else              wcnt_n  = wcnt - 4'd1;
      end

      HALT: begin
        halted = 1'b1;
        if (run) begin
          pc_n    = '0;
          fault_n = 1'b0;
          tcnt_n  = '0;
          state_n = FETCH;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with literal expectations,
// then randomized run/ack/status traffic checked every cycle against an occupancy model.
module tb_fetch_sequencer;

  localparam int EXEC_CYC = 2;
  localparam int TIMEOUT  = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic [2:0]  i0;
  logic [7:0]  i1, i2, i3;
  logic        exec_en;
  logic        alu_status = 1'b0;
  logic [7:0]  pc;
  logic        busy, halted, fault;

  fetch_sequencer #(
    .w(8), .op_w(3), .addr_w(8), .exec_cyc(EXEC_CYC), .timeout(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .run(run),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3), .exec_en(exec_en), .alu_status(alu_status),
    .pc(pc), .busy(busy), .halted(halted), .fault(fault)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  logic [31:0] mem [256];

  // Model: a program runs (m_active) fetching whenever no instruction occupies the
  // datapath; an acked word occupies exec_cyc cycles if it is a datapath op, else 1.
  bit          m_active = 1'b0;
  bit          m_halted = 1'b0;
  bit          m_fault  = 1'b0;
  bit          m_first  = 1'b0;
  logic [7:0]  m_pc     = '0;
  logic [31:0] m_instr  = '0;
  int          m_hold   = 0;
  int          m_wait   = 0;

  function automatic bit is_dp_op(input logic [31:0] word);
    int op;
    op = int'(word[26:24]);
    return (op >= 1) && (op <= 4);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_active = 1'b0; m_halted = 1'b0; m_fault = 1'b0; m_first = 1'b0;
      m_pc = '0; m_instr = '0; m_hold = 0; m_wait = 0;
    end else if (m_halted) begin
      if (run) begin
        m_halted = 1'b0; m_fault = 1'b0; m_pc = '0; m_active = 1'b1; m_wait = 0;
      end
    end else if (!m_active) begin
      if (run) begin
        m_active = 1'b1; m_wait = 0;
      end
    end else if (m_hold == 0) begin
      if (mem_ack) begin
        m_instr = mem[m_pc];
        m_pc    = m_pc + 8'd1;
        m_hold  = is_dp_op(m_instr) ? EXEC_CYC : 1;
        m_first = 1'b1;
        m_wait  = 0;
      end else begin
        m_wait = m_wait + 1;
        if (m_wait == TIMEOUT) begin
          m_fault = 1'b1; m_halted = 1'b1; m_active = 1'b0; m_wait = 0;
        end
      end
    end else begin
      if (m_first) begin
        case (int'(m_instr[26:24]))
          5: if (alu_status) m_pc = m_instr[23:16];
          6: m_pc = m_instr[23:16];
          7: begin m_halted = 1'b1; m_active = 1'b0; end
          default: ;
        endcase
        m_first = 1'b0;
      end
      m_hold = m_active ? m_hold - 1 : 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_on && !reset) begin
      chk("cmp_mem_req", 32'(mem_req), 32'(m_active && m_hold == 0));
      if (m_active && m_hold == 0) chk("cmp_mem_addr", 32'(mem_addr), 32'(m_pc));
      chk("cmp_pc",      32'(pc),      32'(m_pc));
      chk("cmp_busy",    32'(busy),    32'(m_active));
      chk("cmp_halted",  32'(halted),  32'(m_halted));
      chk("cmp_fault",   32'(fault),   32'(m_fault));
      chk("cmp_exec_en", 32'(exec_en), 32'(m_active && m_first && is_dp_op(m_instr)));
      chk("cmp_i0",      32'(i0),      32'(m_instr[26:24]));
      chk("cmp_i1",      32'(i1),      32'(m_instr[23:16]));
      chk("cmp_i2",      32'(i2),      32'(m_instr[15:8]));
      chk("cmp_i3",      32'(i3),      32'(m_instr[7:0]));
    end
  end

  // Returns at a falling edge with the given inputs applied for the coming rising edge;
  // DUT outputs visible on return belong to the current cycle.
  task automatic cyc(input bit ack, input bit rn, input bit alu);
    @(negedge clock);
    mem_ack    = ack;
    run        = rn;
    alu_status = alu;
    mem_data   = mem[m_pc];
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] wd;
    int r;
    wd = $urandom();
    r  = $urandom_range(19);
    if (r < 3)       wd[26:24] = 3'd0;
    else if (r < 12) wd[26:24] = 3'($urandom_range(4, 1));
    else if (r < 15) wd[26:24] = 3'd5;
    else if (r < 18) wd[26:24] = 3'd6;
    else             wd[26:24] = 3'd7;
    return wd;
  endfunction

  initial begin
    int cnt;
    for (int a = 0; a < 256; a++) mem[a] = rand_word();
    mem[8'h00] = 32'h0100_0102;
    mem[8'h01] = 32'h06FF_0000;
    mem[8'hFF] = 32'h0610_0000;
    mem[8'h10] = 32'h0520_0000;
    mem[8'h11] = 32'h0520_0000;
    mem[8'h20] = 32'h0700_0000;

    #1 reset = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_pc",      32'(pc),      32'd0);
    chk("rst_i0",      32'(i0),      32'd0);
    chk("rst_halted",  32'(halted),  32'd0);
    chk("rst_fault",   32'(fault),   32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    reset  = 1'b0;
    chk_on = 1'b1;

    cyc(0, 1, 0);
    chk("idle_busy", 32'(busy), 32'd0);
    cyc(1, 0, 0);
    chk("f0_req",  32'(mem_req),  32'd1);
    chk("f0_addr", 32'(mem_addr), 32'h00);
    cyc(0, 0, 0);
    chk("x0_exec_en", 32'(exec_en), 32'd1);
    chk("x0_fields",  {5'd0, i0, i1, i2, i3}, 32'h0100_0102);
    chk("x0_pc",      32'(pc),      32'h01);
    chk("x0_req",     32'(mem_req), 32'd0);
    cyc(0, 0, 0);
    chk("w0_exec_en", 32'(exec_en), 32'd0);
    chk("w0_req",     32'(mem_req), 32'd0);
    cyc(1, 0, 0);
    chk("f1_addr", 32'(mem_addr), 32'h01);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("fff_addr", 32'(mem_addr), 32'hFF);
    cyc(0, 0, 0);
    chk("jmp_wrap_pc", 32'(pc), 32'h00);
    cyc(1, 0, 0);
    chk("jmp_target_addr", 32'(mem_addr), 32'h10);
    cyc(0, 0, 0);
    chk("brs0_exec_en", 32'(exec_en), 32'd0);
    cyc(1, 0, 0);
    chk("brs0_next_addr", 32'(mem_addr), 32'h11);
    cyc(0, 0, 1);
    chk("brs1_exec_en", 32'(exec_en), 32'd0);

    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(k == 5, 0, 0);
      if (mem_req && mem_addr == 8'h20) cnt++;
    end
    chk("delay_req_cycles", 32'(cnt), 32'd6);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("halt_halted", 32'(halted),  32'd1);
    chk("halt_busy",   32'(busy),    32'd0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0);
      if (mem_req) cnt++;
    end
    chk("halt_no_req", 32'(cnt), 32'd0);

    cyc(0, 1, 0);
    cnt = 0;
    for (int k = 0; k < TIMEOUT; k++) begin
      cyc(0, 0, 0);
      if (mem_req && mem_addr == 8'h00) cnt++;
    end
    chk("to_req_cycles", 32'(cnt), 32'(TIMEOUT));
    cyc(0, 0, 0);
    chk("to_fault",   32'(fault),   32'd1);
    chk("to_halted",  32'(halted),  32'd1);
    chk("to_mem_req", 32'(mem_req), 32'd0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("rerun_fault", 32'(fault),    32'd0);
    chk("rerun_req",   32'(mem_req),  32'd1);
    chk("rerun_addr",  32'(mem_addr), 32'h00);

    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("mid_pre_req", 32'(mem_req), 32'd1);
    chk("mid_pre_pc",  32'(pc),      32'h01);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(mem_req), 32'd0);
    chk("mid_rst_pc",  32'(pc),      32'd0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0);
      if (busy || mem_req) cnt++;
    end
    chk("post_rst_idle", 32'(cnt), 32'd0);

    for (int n = 0; n < 5000; n++) begin
      int pct;
      pct = (n < 3000) ? 60 : 8;
      cyc(($urandom_range(99) < 32'(pct)), ($urandom_range(99) < 20), 1'($urandom_range(1)));
    end
    cyc(0, 0, 0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
